// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit operands one nibble per cycle through an
// external combinational 4-bit adder slice, least significant nibble first.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for i_Start; slice outputs parked at zero
// RUN   | one nibble per cycle through the external slice, idx selects it
// DONE  | result valid for one cycle (o_Done); i_Start here restarts at once
module nibble_serial_adder #(
  parameter int N_NIBBLES = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Start,
  input  logic [4*N_NIBBLES-1:0] i_A,
  input  logic [4*N_NIBBLES-1:0] i_B,
  input  logic                   i_Cin,
  output logic [3:0]             o_Slice_A,
  output logic [3:0]             o_Slice_B,
  output logic                   o_Slice_Cin,
  input  logic [3:0]             i_Slice_Sum,
  input  logic                   i_Slice_Cout,
  output logic [4*N_NIBBLES-1:0] o_Sum,
  output logic                   o_Cout,
  output logic                   o_Busy,
  output logic                   o_Done
);

  localparam int W     = 4 * N_NIBBLES;
  localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry_reg;

  // State register; reset forces IDLE immediately so Busy/Done drop at once.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; a start is honoured in IDLE and DONE, never in RUN.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (i_Start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        if (i_Start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one slice result folded in per RUN edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      o_Sum     <= '0;
      o_Cout    <= 1'b0;
    end else if (accept) begin
      a_reg     <= i_A;
      b_reg     <= i_B;
      carry_reg <= i_Cin;
      idx       <= '0;
      o_Sum     <= '0;
      o_Cout    <= 1'b0;
    end else if (state == RUN) begin
      for (int k = 0; k < N_NIBBLES; k++) begin
        if (idx == k[IDX_W-1:0]) o_Sum[4*k +: 4] <= i_Slice_Sum;
      end
      carry_reg <= i_Slice_Cout;
      idx       <= idx + IDX_W'(1);
      if (idx == LAST_IDX) o_Cout <= i_Slice_Cout;
    end
  end

  // Slice drive: selected operand nibbles and running carry, zero outside RUN.
  always_comb begin
    o_Slice_A   = 4'd0;
    o_Slice_B   = 4'd0;
    o_Slice_Cin = 1'b0;
    if (state == RUN) begin
      o_Slice_Cin = carry_reg;
      for (int k = 0; k < N_NIBBLES; k++) begin
        if (idx == k[IDX_W-1:0]) begin
          o_Slice_A = a_reg[4*k +: 4];
          o_Slice_B = b_reg[4*k +: 4];
        end
      end
    end
  end

  assign o_Busy = (state == RUN);
  assign o_Done = (state == DONE);

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter N_NIBBLES, default 4: operand width in 4-bit nibbles, so W = 4*N_NIBBLES (16 by default).
REQ-002 The block SHALL have port i_Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_Start, input, 1 bit: request to begin an addition, sampled on each rising edge.
REQ-005 The block SHALL have ports i_A and i_B, input, W bits each: the operands.
REQ-006 The block SHALL have port i_Cin, input, 1 bit: carry-in to the least significant nibble.
REQ-007 The block SHALL have ports o_Slice_A and o_Slice_B, output, 4 bits each: current operand nibbles, driving the external 4-bit adder slice.
REQ-008 The block SHALL have port o_Slice_Cin, output, 1 bit: current carry into the slice.
REQ-009 The block SHALL have port i_Slice_Sum, input, 4 bits: the slice's combinational sum.
REQ-010 The block SHALL have port i_Slice_Cout, input, 1 bit: the slice's combinational carry-out.
REQ-011 The block SHALL have port o_Sum, output, W bits: the registered result.
REQ-012 The block SHALL have port o_Cout, output, 1 bit: the registered final carry-out.
REQ-013 The block SHALL have port o_Busy, output, 1 bit: high while in state RUN.
REQ-014 The block SHALL have port o_Done, output, 1 bit: a one-cycle pulse marking a valid result.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, and a nibble index idx of width ceil(log2(N_NIBBLES)), minimum 1 bit.
REQ-016 In IDLE with i_Start=1 the block SHALL do all of the following:
- latch i_A, i_B and i_Cin into operand and carry registers;
- clear o_Sum and o_Cout to 0;
- set idx=0;
- enter RUN.
REQ-017 In RUN the block SHALL drive the following combinationally:
- o_Slice_A = A_reg[4*idx+3:4*idx];
- o_Slice_B = B_reg[4*idx+3:4*idx];
- o_Slice_Cin = carry register.
REQ-018 In IDLE and DONE the block SHALL drive o_Slice_A=0, o_Slice_B=0 and o_Slice_Cin=0.
REQ-019 On each RUN edge the block SHALL write i_Slice_Sum into o_Sum[4*idx+3:4*idx], load i_Slice_Cout into the carry register, and increment idx.
REQ-020 On the RUN edge with idx=N_NIBBLES-1 the block SHALL also load i_Slice_Cout into o_Cout and enter DONE.
REQ-021 Latency: o_Done SHALL be high in exactly the cycle beginning N_NIBBLES rising edges after the edge that accepted i_Start.
REQ-022 o_Done SHALL be 1 only in DONE and SHALL be a single-cycle pulse.
REQ-023 From DONE, the next state SHALL be RUN if i_Start=1 (accepted exactly as in REQ-016), otherwise IDLE.
REQ-024 i_Start SHALL be ignored in RUN; operand registers SHALL NOT change during RUN, even if i_A or i_B change.
REQ-025 o_Sum and o_Cout SHALL hold their values after DONE until the next accepted start.
REQ-026 Arithmetic: on DONE, {o_Cout, o_Sum} SHALL equal A_reg + B_reg + Cin_reg, modulo 2^(W+1).

Reset
REQ-027 While i_Rst=1, the following SHALL hold immediately, independent of the clock:
- state=IDLE, idx=0;
- operand and carry registers = 0;
- o_Sum=0, o_Cout=0, o_Busy=0, o_Done=0;
- slice outputs = 0.
REQ-028 Reset asserted during RUN SHALL abort the operation with no o_Done pulse.
REQ-029 The first i_Start SHALL be accepted on the first rising edge after i_Rst deasserts.

Verification
REQ-030 i_A=0x1234, i_B=0x4321, i_Cin=0, i_Start pulsed -> o_Busy high for 4 cycles, then o_Done pulses with o_Sum=0x5555 and o_Cout=0.
REQ-031 i_A=0xFFFF, i_B=0x0001, i_Cin=0 -> o_Sum=0x0000, o_Cout=1; o_Slice_Cin=1 on nibbles 1-3.
REQ-032 i_A=0xFFFF, i_B=0x0000, i_Cin=1 -> o_Sum=0x0000, o_Cout=1 (carry propagates through all nibbles).
REQ-033 Start 0x0001+0x0001, then during RUN change i_A to 0xAAAA and pulse i_Start -> result is 0x0002 and no second operation starts.
REQ-034 i_Start held high through DONE with i_A=0x00F0, i_B=0x0010 -> back-to-back run with a single-cycle o_Done each time; second result is 0x0100.
REQ-035 Assert i_Rst after 2 RUN cycles -> all outputs 0 at once and no o_Done; a following start of 0x8000+0x8000 gives o_Sum=0x0000 and o_Cout=1.
